ecg_phase_ctrl: RTL and testbench

// - Heart-rate phase generator feeding the ECG LUT waveform stage: its phase_acc output drives the LUT address directly.
// - Accumulates a programmable step on each sample tick and exports the top ADDR_W bits as the LUT address.
// - Rate changes are deferred to the next beat boundary so the waveform never jumps mid-beat.
// - On stop, the current beat is drained to completion before the phase parks at 0.

---
 rtl/ecg_phase_ctrl.sv | 146 ++++++++++++++
 tb/tb_ecg_phase_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ecg_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecg_phase_ctrl
// Purpose  : Heart-rate phase generator for the ECG LUT stage. A step is
//            accumulated on every sample tick and the accumulator MSBs form
//            the LUT address. Rate changes and stop requests take effect
//            only at a beat boundary, so the waveform never jumps mid-beat.
// Revision : 1.0  initial release
// ============================================================================
module ecg_phase_ctrl #(
   parameter int unsigned              ACC_W        = 24,
   parameter int unsigned              ADDR_W       = 10,
   parameter logic        [ACC_W-1:0]  DEFAULT_STEP = 24'h004000,
   parameter int unsigned              CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              tick,
   input  logic [ACC_W-1:0]  step_in,
   input  logic              step_valid,
   output logic              step_ready,
   output logic              step_err,
   output logic [ADDR_W-1:0] phase_acc,
   output logic              beat_start,
   output logic [CNT_W-1:0]  beat_count,
   output logic              running
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W:0]   sum;
   logic             carry;
   logic [ACC_W-1:0] cur_step;
   logic [ACC_W-1:0] pend_step;
   logic             pend_valid;
   logic             accept;
   logic             load_pend;
   logic             count_beat;
   logic             beat_start_d;

   // The pending slot doubles as the handshake: a single buffered step.
   assign step_ready = ~pend_valid;
   assign accept     = step_valid & ~pend_valid;
   assign phase_acc  = acc[ACC_W-1 -: ADDR_W];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_STOP;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath control; RUN and DRAIN share the advance logic
   // and differ only in whether en is still asserted.
   always_comb begin
      state_nxt    = state;
      acc_d        = acc;
      load_pend    = 1'b0;
      count_beat   = 1'b0;
      beat_start_d = 1'b0;
      sum          = {1'b0, acc} + {1'b0, cur_step};
      carry        = sum[ACC_W];
      case (state)
         ST_STOP: begin
            acc_d     = '0;
            load_pend = pend_valid;
            if (en) begin
               state_nxt    = ST_RUN;
               beat_start_d = 1'b1;
            end
         end
         ST_RUN, ST_DRAIN: begin
            state_nxt = en ? ST_RUN : ST_DRAIN;
            if (tick) begin
               acc_d = sum[ACC_W-1:0];
               if (carry) begin
                  count_beat = 1'b1;
                  load_pend  = pend_valid;
                  if (en) begin
                     beat_start_d = 1'b1;
                  end else begin
                     state_nxt = ST_STOP;
                     acc_d     = '0;
                  end
               end
            end
         end
         default: begin
            state_nxt = ST_STOP;
            acc_d     = '0;
         end
      endcase
   end

   // Accumulator, beat counter and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         beat_count <= '0;
         beat_start <= 1'b0;
         running    <= 1'b0;
         step_err   <= 1'b0;
      end else begin
         acc        <= acc_d;
         beat_start <= beat_start_d;
         running    <= (state_nxt != ST_STOP);
         step_err   <= accept & (step_in == '0);
         if (count_beat) begin
            beat_count <= beat_count + CNT_W'(1);
         end
      end
   end

   // Step buffering: a zero step is rejected, a pending step is promoted to
   // the active rate only at a beat boundary or while stopped.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_step   <= DEFAULT_STEP;
         pend_step  <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (accept && (step_in != '0)) begin
            pend_step  <= step_in;
            pend_valid <= 1'b1;
         end else if (load_pend) begin
            pend_valid <= 1'b0;
         end
         if (load_pend) begin
            cur_step <= pend_step;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ecg_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecg_phase_ctrl
// Purpose  : Directed vector table plus multi-cycle sequences for
//            ecg_phase_ctrl with hand-computed expected outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_ecg_phase_ctrl;

   logic        clk;
   logic        reset;
   logic        en;
   logic        tick;
   logic [23:0] step_in;
   logic        step_valid;
   logic        step_ready;
   logic        step_err;
   logic [9:0]  phase_acc;
   logic        beat_start;
   logic [15:0] beat_count;
   logic        running;

   int checks;
   int failures;

   typedef struct {
      logic        en;
      logic        tick;
      logic        sv;
      logic [23:0] step;
      logic [9:0]  ph;
      logic        bs;
      logic        run;
      logic        rdy;
      logic        err;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];

   ecg_phase_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .tick       (tick),
      .step_in    (step_in),
      .step_valid (step_valid),
      .step_ready (step_ready),
      .step_err   (step_err),
      .phase_acc  (phase_acc),
      .beat_start (beat_start),
      .beat_count (beat_count),
      .running    (running)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic e, input logic t, input logic sv, input logic [23:0] s,
                      input logic [9:0] ph, input logic bs, input logic run,
                      input logic rdy, input logic err, input logic [15:0] cnt);
      vec_t v;
      v.en = e; v.tick = t; v.sv = sv; v.step = s;
      v.ph = ph; v.bs = bs; v.run = run; v.rdy = rdy; v.err = err; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   initial begin
      int bad;
      int exp_ph;
      checks   = 0;
      failures = 0;
      reset      = 1'b1;
      en         = 1'b0;
      tick       = 1'b0;
      step_in    = '0;
      step_valid = 1'b0;

      // Fast-rate vectors: 0x400000 gives +256 per tick (4 ticks per beat),
      // 0x200000 gives +128 per tick.
      //   en tick sv step        ph  bs run rdy err cnt
      add(0, 0, 1, 24'h400000,   0, 0, 0, 0, 0, 0); // step buffered
      add(0, 0, 0, 24'h000000,   0, 0, 0, 1, 0, 0); // STOP loads it
      add(1, 1, 0, 24'h000000,   0, 1, 1, 1, 0, 0); // start, beat_start
      add(1, 1, 0, 24'h000000, 256, 0, 1, 1, 0, 0);
      add(1, 1, 0, 24'h000000, 512, 0, 1, 1, 0, 0);
      add(1, 0, 0, 24'h000000, 512, 0, 1, 1, 0, 0); // no tick: hold
      add(1, 1, 0, 24'h000000, 768, 0, 1, 1, 0, 0);
      add(1, 1, 0, 24'h000000,   0, 1, 1, 1, 0, 1); // wrap
      add(1, 1, 1, 24'h200000, 256, 0, 1, 0, 0, 1); // mid-beat rate change
      add(1, 1, 0, 24'h000000, 512, 0, 1, 0, 0, 1);
      add(1, 1, 0, 24'h000000, 768, 0, 1, 0, 0, 1);
      add(1, 1, 0, 24'h000000,   0, 1, 1, 1, 0, 2); // new rate at wrap
      add(1, 1, 0, 24'h000000, 128, 0, 1, 1, 0, 2);
      add(0, 1, 0, 24'h000000, 256, 0, 1, 1, 0, 2); // DRAIN
      add(0, 0, 0, 24'h000000, 256, 0, 1, 1, 0, 2);
      add(1, 1, 0, 24'h000000, 384, 0, 1, 1, 0, 2); // back to RUN
      add(0, 1, 0, 24'h000000, 512, 0, 1, 1, 0, 2);
      add(0, 1, 0, 24'h000000, 640, 0, 1, 1, 0, 2);
      add(0, 1, 0, 24'h000000, 768, 0, 1, 1, 0, 2);
      add(0, 1, 0, 24'h000000, 896, 0, 1, 1, 0, 2);
      add(0, 1, 0, 24'h000000,   0, 0, 0, 1, 0, 3); // drained, stopped
      add(0, 0, 1, 24'h000000,   0, 0, 0, 1, 1, 3); // zero step rejected
      add(0, 0, 1, 24'h400000,   0, 0, 0, 0, 0, 3);
      add(1, 0, 0, 24'h000000,   0, 1, 1, 1, 0, 3); // load + start together
      add(1, 1, 0, 24'h000000, 256, 0, 1, 1, 0, 3); // first beat uses new step
      add(1, 1, 0, 24'h000000, 512, 0, 1, 1, 0, 3);
      add(1, 1, 0, 24'h000000, 768, 0, 1, 1, 0, 3);
      add(1, 1, 1, 24'h200000,   0, 1, 1, 0, 0, 4); // accept on wrap cycle
      add(1, 1, 0, 24'h000000, 256, 0, 1, 0, 0, 4); // not applied yet
      add(1, 1, 0, 24'h000000, 512, 0, 1, 0, 0, 4);
      add(1, 1, 0, 24'h000000, 768, 0, 1, 0, 0, 4);
      add(1, 1, 0, 24'h000000,   0, 1, 1, 1, 0, 5);
      add(1, 1, 0, 24'h000000, 128, 0, 1, 1, 0, 5);
      add(0, 0, 0, 24'h000000, 128, 0, 1, 1, 0, 5);

      // Reset state.
      cyc();
      check("rst_phase", 32'(phase_acc), 0);
      check("rst_running", 32'(running), 0);
      check("rst_beat_start", 32'(beat_start), 0);
      check("rst_beat_count", 32'(beat_count), 0);
      check("rst_step_ready", 32'(step_ready), 1);
      check("rst_step_err", 32'(step_err), 0);
      reset = 1'b0;

      // Vector table.
      for (int i = 0; i < tbl.size(); i++) begin
         en = tbl[i].en; tick = tbl[i].tick;
         step_valid = tbl[i].sv; step_in = tbl[i].step;
         cyc();
         check($sformatf("v%0d_phase", i), 32'(phase_acc), 32'(tbl[i].ph));
         check($sformatf("v%0d_beat_start", i), 32'(beat_start), 32'(tbl[i].bs));
         check($sformatf("v%0d_running", i), 32'(running), 32'(tbl[i].run));
         check($sformatf("v%0d_step_ready", i), 32'(step_ready), 32'(tbl[i].rdy));
         check($sformatf("v%0d_step_err", i), 32'(step_err), 32'(tbl[i].err));
         check($sformatf("v%0d_beat_count", i), 32'(beat_count), 32'(tbl[i].cnt));
      end
      step_valid = 1'b0;

      // Full default-rate beat: 0..1023 then wrap.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      en = 1'b1; tick = 1'b1;
      cyc();
      check("b1_start_pulse", 32'(beat_start), 1);
      check("b1_start_phase", 32'(phase_acc), 0);
      bad = 0;
      for (int i = 1; i < 1024; i++) begin
         cyc();
         if (phase_acc !== 10'(i) || beat_start !== 1'b0) bad++;
      end
      check("b1_walk_errors", 32'(bad), 0);
      cyc();
      check("b1_wrap_phase", 32'(phase_acc), 0);
      check("b1_wrap_pulse", 32'(beat_start), 1);
      check("b1_wrap_count", 32'(beat_count), 1);

      // Step pending mid-beat, then reset at phase 700 discards it.
      bad = 0;
      for (int i = 1; i <= 700; i++) begin
         cyc();
         if (phase_acc !== 10'(i)) bad++;
         if (i == 101) check("rst5_pending_ready", 32'(step_ready), 0);
         step_valid = (i == 100);
         step_in    = (i == 100) ? 24'h008000 : 24'h0;
      end
      check("rst5_walk_errors", 32'(bad), 0);
      check("rst5_phase700", 32'(phase_acc), 700);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("rst5_phase", 32'(phase_acc), 0);
      check("rst5_running", 32'(running), 0);
      check("rst5_ready", 32'(step_ready), 1);
      cyc();
      check("rst5_restart_pulse", 32'(beat_start), 1);
      cyc();
      check("rst5_default_step", 32'(phase_acc), 1);

      // Tick every 4th cycle: phase moves only after tick cycles.
      exp_ph = 1;
      bad = 0;
      for (int c = 0; c < 32; c++) begin
         tick = ((c % 4) == 0);
         cyc();
         if (tick) exp_ph++;
         if (phase_acc !== 10'(exp_ph)) bad++;
      end
      check("tick4_errors", 32'(bad), 0);
      check("tick4_phase", 32'(phase_acc), 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
